// File: rtl/param_sequence_detector_if.sv
// rtl/param_sequence_detector_if.sv - serial stream, configuration and status bundle for the sequence detector
interface param_sequence_detector_if #(
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 16
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic               seq;
  logic               valid;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               cnt_clear;
  logic               detected;
  logic [CNT_W-1:0]   match_count;
  logic               cnt_sat;
  logic               cfg_err;

  modport master (
    output seq, valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clear,
    input  detected, match_count, cnt_sat, cfg_err
  );

  modport slave (
    input  seq, valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clear,
    output detected, match_count, cnt_sat, cfg_err
  );
endinterface

// File: rtl/param_sequence_detector.sv
// rtl/param_sequence_detector.sv - runtime-configurable serial pattern detector with saturating match counter
module param_sequence_detector #(
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      resetn,
  param_sequence_detector_if.slave  bus
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  typedef enum logic [1:0] {UNCFG, FILL, ARMED} state_t;

  state_t             state, state_next;
  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q;
  logic               overlap_q;
  logic [MAX_LEN-1:0] hist_q;
  logic [LEN_W-1:0]   fill_q;
  logic               detected_q;
  logic [CNT_W-1:0]   count_q;
  logic               sat_q;
  logic               cfg_err_c;

  logic               load_len_ok;
  logic               beat;
  logic [MAX_LEN-1:0] hist_next;
  logic [LEN_W-1:0]   fill_next;
  logic [MAX_LEN-1:0] len_mask;
  logic               match;

  always_comb begin
    load_len_ok = (bus.cfg_len != '0) && (bus.cfg_len <= MAX_LEN_L);
    beat        = bus.valid && !bus.cfg_load && (state != UNCFG);
    hist_next   = {hist_q[MAX_LEN-2:0], bus.seq};
    fill_next   = (fill_q >= MAX_LEN_L) ? MAX_LEN_L : fill_q + 1'b1;
    len_mask    = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (int'(len_q) > i);
    end
    match = beat && (fill_next >= len_q) && (((hist_next ^ pattern_q) & len_mask) == '0);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= UNCFG;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; cfg_load always wins over a coinciding beat
  always_comb begin
    state_next = state;
    if (bus.cfg_load) begin
      state_next = load_len_ok ? FILL : UNCFG;
    end else if (match && !overlap_q) begin
      state_next = FILL;
    end else if (beat) begin
      state_next = (fill_next >= len_q) ? ARMED : FILL;
    end
  end

  // Output logic: the latched length is only invalid while unconfigured
  always_comb begin
    cfg_err_c = (state == UNCFG);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pattern_q  <= '0;
      len_q      <= '0;
      overlap_q  <= 1'b1;
      hist_q     <= '0;
      fill_q     <= '0;
      detected_q <= 1'b0;
      count_q    <= '0;
      sat_q      <= 1'b0;
    end else begin
      detected_q <= match;
      if (bus.cfg_load) begin
        pattern_q <= bus.cfg_pattern;
        len_q     <= bus.cfg_len;
        overlap_q <= bus.cfg_overlap;
        hist_q    <= '0;
        fill_q    <= '0;
      end else if (match && !overlap_q) begin
        hist_q <= '0;
        fill_q <= '0;
      end else if (beat) begin
        hist_q <= hist_next;
        fill_q <= fill_next;
      end

      // Clear overrides a simultaneous match; the pulse itself still fires
      if (bus.cnt_clear) begin
        count_q <= '0;
        sat_q   <= 1'b0;
      end else if (match) begin
        if (&count_q) begin
          sat_q <= 1'b1;
        end else begin
          count_q <= count_q + 1'b1;
        end
      end
    end
  end

  assign bus.detected    = detected_q;
  assign bus.match_count = count_q;
  assign bus.cnt_sat     = sat_q;
  assign bus.cfg_err     = cfg_err_c;
endmodule

// File: tb/tb_param_sequence_detector.sv
// tb/tb_param_sequence_detector.sv - scoreboard bench for param_sequence_detector
module tb_param_sequence_detector;
  localparam int MAX_LEN = 16;
  localparam int CNT_W   = 2;

  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   errors = 0;
  int   exp_q[$];

  always #5 clk = ~clk;

  param_sequence_detector_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();

  param_sequence_detector #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every detect pulse must match a queued expectation carrying the count it should show
  always @(negedge clk) begin
    if (bus.detected === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_detect: got 1 expected 0 at %0t", $time);
      end else begin
        check("detect_count", 32'(bus.match_count), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic b, input logic exp_det, input int exp_cnt);
    bus.valid = 1'b1;
    bus.seq   = b;
    if (exp_det) exp_q.push_back(exp_cnt);
    cycle();
    bus.valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic load(input logic [15:0] pat, input logic [4:0] len, input logic ov,
                      input logic with_beat);
    bus.cfg_load    = 1'b1;
    bus.cfg_pattern = pat;
    bus.cfg_len     = len;
    bus.cfg_overlap = ov;
    bus.valid       = with_beat;
    bus.seq         = 1'b1;
    cycle();
    bus.cfg_load = 1'b0;
    bus.valid    = 1'b0;
  endtask

  task automatic clear();
    bus.cnt_clear = 1'b1;
    cycle();
    bus.cnt_clear = 1'b0;
  endtask

  task automatic settle(input string name, input int exp_cnt, input logic exp_sat);
    idle(2);
    @(negedge clk);
    check({name, "_count"}, 32'(bus.match_count), 32'(exp_cnt));
    check({name, "_sat"}, 32'(bus.cnt_sat), 32'(exp_sat));
    check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    #1;
  endtask

  initial begin
    resetn          = 1'b0;
    bus.seq         = 1'b0;
    bus.valid       = 1'b0;
    bus.cfg_load    = 1'b0;
    bus.cfg_pattern = '0;
    bus.cfg_len     = '0;
    bus.cfg_overlap = 1'b0;
    bus.cnt_clear   = 1'b0;
    idle(2);
    resetn = 1'b1;
    @(negedge clk);
    check("rst_cfg_err", 32'(bus.cfg_err), 32'd1);
    check("rst_count", 32'(bus.match_count), 32'd0);
    check("rst_sat", 32'(bus.cnt_sat), 32'd0);
    check("rst_detected", 32'(bus.detected), 32'd0);
    #1;

    // Overlap: 1,0,1,1,0,1,1,0 against 10110 matches at beats 5 and 8
    load(16'b10110, 5'd5, 1'b1, 1'b0);
    @(negedge clk);
    check("ovl_cfg_err", 32'(bus.cfg_err), 32'd0);
    #1;
    beat(1, 0, 0); beat(0, 0, 0); beat(1, 0, 0); beat(1, 0, 0);
    beat(0, 1, 1); beat(1, 0, 0); beat(1, 0, 0); beat(0, 1, 2);
    settle("ovl", 2, 0);

    // Non-overlap: history restarts after beat 5, so beat 8 no longer matches
    clear();
    load(16'b10110, 5'd5, 1'b0, 1'b0);
    beat(1, 0, 0); beat(0, 0, 0); beat(1, 0, 0); beat(1, 0, 0);
    beat(0, 1, 1); beat(1, 0, 0); beat(1, 0, 0); beat(0, 0, 0);
    settle("novl", 1, 0);

    // Gaps of three idle cycles between beats do not break the partial match
    clear();
    load(16'b10110, 5'd5, 1'b1, 1'b0);
    beat(1, 0, 0); idle(3); beat(0, 0, 0); idle(3); beat(1, 0, 0); idle(3);
    beat(1, 0, 0); idle(3); beat(0, 1, 1); idle(3);
    settle("gap", 1, 0);

    // len=1 saturation on a 2-bit counter, then clear colliding with a match
    clear();
    load(16'b1, 5'd1, 1'b0, 1'b0);
    beat(1, 1, 1); beat(1, 1, 2); beat(1, 1, 3);
    beat(1, 1, 3); beat(1, 1, 3); beat(1, 1, 3);
    beat(0, 0, 0);
    settle("sat", 3, 1);
    bus.cnt_clear = 1'b1;
    beat(1, 1, 0);
    bus.cnt_clear = 1'b0;
    settle("clrwin", 0, 0);

    // Invalid lengths: zero and MAX_LEN+1 leave the block unconfigured
    load(16'hFFFF, 5'd0, 1'b1, 1'b0);
    @(negedge clk);
    check("len0_cfg_err", 32'(bus.cfg_err), 32'd1);
    #1;
    beat(1, 0, 0); beat(1, 0, 0); beat(1, 0, 0); beat(1, 0, 0);
    load(16'hFFFF, 5'd17, 1'b1, 1'b0);
    @(negedge clk);
    check("len17_cfg_err", 32'(bus.cfg_err), 32'd1);
    #1;
    beat(1, 0, 0); beat(1, 0, 0);
    settle("cfgerr", 0, 0);

    // Reload with a coinciding 1-beat that must be dropped; upper pattern bits are don't-care
    load(16'hFFF5, 5'd3, 1'b1, 1'b1);
    @(negedge clk);
    check("len3_cfg_err", 32'(bus.cfg_err), 32'd0);
    #1;
    beat(0, 0, 0); beat(1, 0, 0); beat(0, 0, 0); beat(1, 1, 1);
    settle("prio", 1, 0);

    // Reset mid-pattern discards everything and returns to unconfigured
    clear();
    load(16'b10110, 5'd5, 1'b1, 1'b0);
    beat(1, 0, 0); beat(0, 0, 0); beat(1, 0, 0); beat(1, 0, 0);
    resetn = 1'b0;
    cycle();
    resetn = 1'b1;
    @(negedge clk);
    check("midrst_detected", 32'(bus.detected), 32'd0);
    check("midrst_cfg_err", 32'(bus.cfg_err), 32'd1);
    #1;
    beat(0, 0, 0);
    settle("midrst", 0, 0);
    @(negedge clk);
    check("midrst_still_err", 32'(bus.cfg_err), 32'd1);
    #1;
    load(16'b10110, 5'd5, 1'b1, 1'b0);
    @(negedge clk);
    check("reload_cfg_err", 32'(bus.cfg_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/param_sequence_detector.md
Name: param_sequence_detector

Overview:
- Runtime-configurable serial bit-pattern detector. Pattern length is 1..MAX_LEN and can be changed at run time.
- Selectable overlapping or non-overlapping match mode.
- Saturating match counter.
- Sits on the same serial `seq`/`valid` stream as the existing fixed-pattern detectors and replaces them with one parametrised block.

Parameters:
- MAX_LEN, 16, maximum pattern length in bits (>=2).
- CNT_W, 16, width of the match counter.
- LEN_W, $clog2(MAX_LEN+1), width of the length field (derived; do not override).

Ports:
- clk  in  1  clock, all logic on rising edge.
- resetn  in  1  synchronous active-low reset.
- seq  in  1  serial data bit, sampled when valid=1.
- valid  in  1  beat qualifier; seq is ignored when low.
- cfg_load  in  1  one-cycle strobe that latches cfg_pattern/cfg_len/cfg_overlap.
- cfg_pattern  in  MAX_LEN  pattern; bit [cfg_len-1] is the first bit received, bit [0] the last.
- cfg_len  in  LEN_W  pattern length.
- cfg_overlap  in  1  1 = overlapping matches allowed; 0 = history restarts after each match.
- cnt_clear  in  1  synchronously zeroes match_count and cnt_sat.
- detected  out  1  registered one-cycle pulse per match.
- match_count  out  CNT_W  number of matches since reset or clear, saturating.
- cnt_sat  out  1  sticky; high once match_count has saturated.
- cfg_err  out  1  high while the latched length is 0 or greater than MAX_LEN.

Behaviour:
- Reset (resetn=0 at a clk edge):
  - pattern register = 0, length = 0, overlap = 1.
  - history = 0, fill = 0, state = UNCFG.
  - detected = 0, match_count = 0, cnt_sat = 0, cfg_err = 1.
- FSM states:
  - UNCFG: no valid configuration is held.
  - FILL: fill < len.
  - ARMED: fill >= len.
- cfg_load=1:
  - Latches all three configuration fields and clears history and fill.
  - If the length is valid, state goes to FILL and cfg_err=0 next cycle. Otherwise state goes to UNCFG and cfg_err=1.
  - cfg_load has priority over valid: a beat coinciding with cfg_load is discarded.
  - cfg_load does not touch match_count.
- Beat accepted when valid=1, cfg_load=0, state != UNCFG:
  - hist_next = {hist[MAX_LEN-2:0], seq}.
  - fill_next = min(fill+1, MAX_LEN).
- Match condition: state is FILL or ARMED, fill_next >= len, and (hist_next XOR pattern) masked to the low len bits equals 0.
- On a match:
  - detected=1 in the cycle after the completing beat (latency 1). It is high for exactly one cycle per match.
  - match_count increments unless it is at all-ones. At all-ones it holds and cnt_sat sets.
  - cfg_overlap=1: history and fill continue.
  - cfg_overlap=0: fill resets to 0 and history to 0; state goes to FILL.
- valid=0: history, fill and state hold, and detected=0 next cycle. Gaps do not break a partial match.
- In UNCFG, beats are ignored and detected stays 0.
- cnt_clear and a match in the same cycle: clear wins; match_count=0, cnt_sat=0. detected still pulses.
- len=1: every beat equal to pattern[0] is a match in either mode.
- Reset mid-stream or mid-pulse: all state is lost. detected is 0 the cycle after the reset edge.
- Pattern bits above len-1 are don't-care.

Test Plan:
- Overlap mode:
  - Stimulus: cfg_pattern=...10110, cfg_len=5, cfg_overlap=1; stream 1,0,1,1,0,1,1,0 on consecutive valid beats.
  - Required: detected pulses the cycle after beat 5 and after beat 8; match_count=2.
- Non-overlap mode:
  - Stimulus: same pattern and stream as above, cfg_overlap=0.
  - Required: single pulse after beat 5; match_count=1.
- Valid gaps:
  - Stimulus: pattern 10110, stream 1,0,1,1,0 with valid low for 3 cycles between every beat.
  - Required: one pulse after the 5th valid beat; no pulse while valid=0.
- Saturation and clear:
  - Stimulus: CNT_W=2, cfg_len=1, pattern bit 1; six 1-beats, then cnt_clear.
  - Required: detected pulses 6 times; match_count stops at 3 with cnt_sat=1; after clear both are 0.
- Config errors and load priority:
  - Stimulus: cfg_len=0 load.
  - Required: cfg_err=1 and a stream of 1s never detects.
  - Stimulus: reload with cfg_len=3, pattern 101, while a valid beat arrives in the same cycle.
  - Required: that beat is discarded; next beats 1,0,1 give a pulse after the third.
- Reset mid-pattern:
  - Stimulus: pattern 10110; send 1,0,1,1; assert resetn=0 for one cycle; send 0.
  - Required: no detect; cfg_err=1 (UNCFG) until a new cfg_load.
